// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port synchronous RAM among N requesters.
// Fixed-priority or round-robin selection, one-cycle read return, saturating grant stats.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 32,
    parameter int N_PORTS = 3,
    parameter int RR_MODE = 0,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          req,
    input  logic [N_PORTS-1:0]          we,
    input  logic [N_PORTS*ADDR_W-1:0]   addr,
    input  logic [N_PORTS*DATA_W-1:0]   wdata,
    output logic [N_PORTS-1:0]          gnt,
    output logic [N_PORTS-1:0]          rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    output logic                        mem_wren,
    input  logic [DATA_W-1:0]           mem_q,
    input  logic                        clr_stats,
    output logic [N_PORTS*CNT_W-1:0]    grant_cnt
);

    localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [IDX_W-1:0]         last;
    logic [IDX_W-1:0]         sel;
    logic                     hit;
    logic [N_PORTS-1:0]       rvalid_q;
    logic [N_PORTS*CNT_W-1:0] cnt_q;

    // Pick the requester closest to the search origin (0 fixed, last+1 round-robin)
    always_comb begin
        int best;
        int d;
        hit  = 1'b0;
        sel  = '0;
        best = N_PORTS;
        d    = 0;
        if (!rst) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (RR_MODE != 0) begin
                    d = i - int'(last) - 1;
                    if (d < 0) d = d + N_PORTS;
                end else begin
                    d = i;
                end
                if (req[i] && d < best) begin
                    best = d;
                    sel  = IDX_W'(i);
                    hit  = 1'b1;
                end
            end
        end
    end

    // One-hot grant and RAM-side mux; idle bus is driven to zero
    always_comb begin
        gnt       = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (hit && sel == IDX_W'(i)) begin
                gnt[i]    = 1'b1;
                mem_addr  = addr[i*ADDR_W +: ADDR_W];
                mem_wdata = wdata[i*DATA_W +: DATA_W];
                mem_wren  = we[i];
            end
        end
    end

    // Track last winner and flag which port owns next cycle's RAM output
    always_ff @(posedge clk) begin
        if (rst) begin
            last     <= '0;
            rvalid_q <= '0;
        end else begin
            rvalid_q <= gnt & ~we;
            if (hit) last <= sel;
        end
    end

    // Reset in the return cycle kills the in-flight read
    assign rvalid = rvalid_q & {N_PORTS{~rst}};
    assign rdata  = mem_q;

    // Saturating per-port grant counters; clear beats a coincident grant
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (gnt[i] && cnt_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})
                    cnt_q[i*CNT_W +: CNT_W] <= cnt_q[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

    assign grant_cnt = cnt_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed checks of fixed, round-robin and
// narrow-counter arbiter instances sharing one stimulus stream.
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [2:0]  we;
    logic [32:0] addr;
    logic [95:0] wdata;
    logic        clr;
    logic [31:0] ram_q;

    logic [2:0]  gnt_f, rvalid_f, gnt_r, rvalid_r, gnt_s, rvalid_s;
    logic [31:0] rdata_f, rdata_r, rdata_s;
    logic [10:0] maddr_f, maddr_r, maddr_s;
    logic [31:0] mwd_f, mwd_r, mwd_s;
    logic        mwren_f, mwren_r, mwren_s;
    logic [47:0] cnt_f, cnt_r;
    logic [11:0] cnt_s;

    logic [31:0] ram [0:2047];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // RAM model with one-cycle read latency, driven by the fixed instance
    always @(posedge clk) begin
        if (mwren_f) ram[maddr_f] <= mwd_f;
        ram_q <= ram[maddr_f];
    end

    unified_mem_arbiter #(.RR_MODE(0), .CNT_W(16)) u_fix (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt_f), .rvalid(rvalid_f), .rdata(rdata_f), .mem_addr(maddr_f),
        .mem_wdata(mwd_f), .mem_wren(mwren_f), .mem_q(ram_q),
        .clr_stats(clr), .grant_cnt(cnt_f)
    );

    unified_mem_arbiter #(.RR_MODE(1), .CNT_W(16)) u_rr (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt_r), .rvalid(rvalid_r), .rdata(rdata_r), .mem_addr(maddr_r),
        .mem_wdata(mwd_r), .mem_wren(mwren_r), .mem_q(ram_q),
        .clr_stats(clr), .grant_cnt(cnt_r)
    );

    unified_mem_arbiter #(.RR_MODE(0), .CNT_W(4)) u_sat (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt_s), .rvalid(rvalid_s), .rdata(rdata_s), .mem_addr(maddr_s),
        .mem_wdata(mwd_s), .mem_wren(mwren_s), .mem_q(ram_q),
        .clr_stats(clr), .grant_cnt(cnt_s)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        logic [2:0] rr_seq [6];
        rr_seq = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};

        rst = 1'b1; req = 3'b111; we = 3'b000;
        addr = '0; wdata = '0; clr = 1'b0;
        cyc(); cyc(); settle();
        chk("rst_gnt_f", gnt_f, 3'b000);
        chk("rst_gnt_r", gnt_r, 3'b000);
        chk("rst_wren", mwren_f, 1'b0);
        chk("rst_rvalid", rvalid_f, 3'b000);
        chk("rst_addr", maddr_f, 11'd0);
        chk("rst_cnt", cnt_f, 48'd0);

        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("fix_gnt", gnt_f, 3'b001);
            chk("rr_gnt", gnt_r, rr_seq[i]);
            cyc();
            if (i == 3) begin
                chk("fix_cnt4", cnt_f, {16'd0, 16'd0, 16'd4});
                chk("fix_rvalid", rvalid_f, 3'b001);
            end
        end
        chk("rr_cnt", cnt_r, {16'd2, 16'd2, 16'd2});

        rst = 1'b1; req = 3'b000;
        cyc();
        rst = 1'b0; req = 3'b010; we = 3'b010;
        addr[11 +: 11] = 11'h005;
        wdata[32 +: 32] = 32'hDEADBEEF;
        settle();
        chk("wr_gnt", gnt_f, 3'b010);
        chk("wr_wren", mwren_f, 1'b1);
        chk("wr_addr", maddr_f, 11'h005);
        chk("wr_wdata", mwd_f, 32'hDEADBEEF);
        cyc();
        we = 3'b000;
        settle();
        chk("rd_gnt", gnt_f, 3'b010);
        chk("rd_wren", mwren_f, 1'b0);
        chk("rd_addr", maddr_f, 11'h005);
        chk("wr_no_rvalid", rvalid_f, 3'b000);
        cyc();
        req = 3'b000;
        settle();
        chk("rd_rvalid", rvalid_f, 3'b010);
        chk("rd_rdata", rdata_f, 32'hDEADBEEF);
        chk("idle_gnt", gnt_f, 3'b000);
        chk("idle_addr", maddr_f, 11'd0);
        chk("idle_wdata", mwd_f, 32'd0);
        chk("idle_wren", mwren_f, 1'b0);

        rst = 1'b1;
        cyc();
        rst = 1'b0; req = 3'b011;
        settle();
        chk("mid_gnt_f", gnt_f, 3'b001);
        chk("mid_gnt_r", gnt_r, 3'b010);
        cyc();
        rst = 1'b1; req = 3'b000;
        settle();
        chk("mid_rvalid_f", rvalid_f, 3'b000);
        chk("mid_rvalid_r", rvalid_r, 3'b000);
        cyc();
        rst = 1'b0; req = 3'b111;
        settle();
        chk("mid_cnt_f", cnt_f, 48'd0);
        chk("mid_cnt_r", cnt_r, 48'd0);
        chk("mid_last", gnt_r, 3'b010);
        chk("mid_rvalid_after", rvalid_f, 3'b000);

        rst = 1'b1; req = 3'b000;
        cyc();
        rst = 1'b0; req = 3'b100;
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (i == 14) chk("sat_cnt14", cnt_s[8 +: 4], 4'd14);
            if (i == 15) chk("sat_cnt15", cnt_s[8 +: 4], 4'd15);
        end
        settle();
        chk("sat_hold", cnt_s[8 +: 4], 4'd15);
        chk("sat_low", cnt_s[7:0], 8'd0);
        clr = 1'b1;
        settle();
        chk("clr_gnt", gnt_s, 3'b100);
        cyc();
        clr = 1'b0; req = 3'b000;
        settle();
        chk("clr_cnt", cnt_s, 12'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Parametrised N-port arbiter that lets several requesters (instruction fetch, data load/store, debug/loader port) share one single-port synchronous RAM with one-cycle read latency. Sits between the CPU core and a single `data_mem`-style RAM macro, replacing separate instruction and data memories with one shared array. Supports fixed-priority or round-robin arbitration. Keeps per-port saturating grant counters for on-board debug display.

## Interface
- `ADDR_W`, 11, word address width.
- `DATA_W`, 32, data width.
- `N_PORTS`, 3, number of requesters (≥2); port 0 = instruction fetch by convention.
- `RR_MODE`, 0, 0 = fixed priority (lowest index wins); 1 = round-robin.
- `CNT_W`, 16, grant counter width.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req` input N_PORTS: per-port request.
- `we` input N_PORTS: per-port write enable (qualified by `req`).
- `addr` input N_PORTS*ADDR_W: port p at bits [p*ADDR_W +: ADDR_W].
- `wdata` input N_PORTS*DATA_W: port p at bits [p*DATA_W +: DATA_W].
- `gnt` output N_PORTS: one-hot grant, combinational.
- `rvalid` output N_PORTS: one-hot read-data-valid, registered.
- `rdata` output DATA_W: read data, shared by all ports, meaningful only with `rvalid`.
- `mem_addr` output ADDR_W: to RAM address.
- `mem_wdata` output DATA_W: to RAM data.
- `mem_wren` output 1: to RAM write enable.
- `mem_q` input DATA_W: RAM output, valid one cycle after address is presented.
- `clr_stats` input 1: synchronous clear of grant counters.
- `grant_cnt` output N_PORTS*CNT_W: per-port grant counters, port p at [p*CNT_W +: CNT_W].

## Operation
- Each cycle, at most one port is granted; `gnt` is zero when `rst`=1 or `req`=0.
- Fixed mode: the lowest-index requesting port wins.
- Round-robin mode:
  - Register `last` (reset 0) holds the index of the most recent grant.
  - Search starts at `last+1` modulo N_PORTS and picks the first requester.
  - `last` updates only on a grant.
- Granted port drives `mem_addr`, `mem_wdata`, and `mem_wren = we[p]`.
- When there is no grant: `mem_addr`=0, `mem_wdata`=0, `mem_wren`=0.
- Requester rules:
  - Hold `req`, `we`, `addr`, `wdata` stable until it sees `gnt`.
  - It may drop `req` or present a new request in the cycle after `gnt`.
- Read grant (`we`=0) in cycle T:
  - `rvalid[p]`=1 in T+1.
  - `rdata` = `mem_q` in T+1, passed through combinationally with `rvalid` registered.
- Write grants produce no `rvalid`.
- Grant counters:
  - `grant_cnt[p]` increments on every grant to p.
  - Counters saturate at 2^CNT_W−1.
  - `clr_stats` zeroes all counters; if a grant coincides with clear, the clear wins (result 0).
- Read-after-write to the same address in consecutive cycles returns the new data. Ordering follows the RAM's single port; the arbiter adds no bypass.

## Timing
- Reset values:
  - `gnt`=0, `rvalid`=0, `mem_wren`=0, `mem_addr`=0, `mem_wdata`=0.
  - `last`=0, all `grant_cnt`=0.
- Read latency: 1 cycle from `gnt` to `rvalid`.
- Throughput: one access per cycle, back-to-back grants to any mix of ports.
- `rst` asserted in the cycle after a read grant: `rvalid` stays 0, and the in-flight read is discarded.
- Simultaneous requests from all ports in round-robin mode:
  - Grants rotate p, p+1, …, wrapping N_PORTS−1 → 0.
  - No port waits more than N_PORTS−1 cycles.
- Fixed mode starvation of high indices is permitted and expected.
- All registered state changes only on rising `clk`.

## Test plan
- Reset: hold `rst`=1 with all `req`=1 → `gnt`=0, `mem_wren`=0, `rvalid`=0. Release → port 0 granted in the first cycle.
- Write then read:
  - Port 1 writes 0xDEADBEEF to addr 0x005, then reads 0x005 next cycle.
  - Required: `gnt[1]` both cycles; `mem_wren` 1 then 0; `rvalid[1]`=1 one cycle after the read grant with `rdata`=0xDEADBEEF.
- Fixed priority (RR_MODE=0), ports 0, 1, 2 all requesting for 4 cycles → `gnt`=001 every cycle; `grant_cnt[0]`=4, others 0.
- Round-robin (RR_MODE=1), all ports requesting for 6 cycles → grant sequence 1, 2, 0, 1, 2, 0 (`last`=0 after reset); each counter =2.
- Reset mid-read: grant a port 0 read in cycle T, assert `rst` in T+1 → `rvalid`=0 in T+1; `last` and counters cleared.
- Counter saturation and clear:
  - Setup: CNT_W=4, port 2 requesting for 20 cycles.
  - `grant_cnt[2]` reaches 15 and holds.
  - `clr_stats` with a simultaneous grant → counter 0.
